// File: rtl/hs32_sram_pkg.sv
// hs32_sram_pkg: shared FSM/grant encodings and constants for the HS32 SRAM arbiter
package hs32_sram_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_t;
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_WB = 1'b1;
    localparam int SRAM_RD_LAT = 1;
    localparam int DEFAULT_AW = 8;
endpackage

// File: rtl/hs32_rr_arb2.sv
// hs32_rr_arb2: two-request picker, round-robin on last grant or fixed CPU priority
module hs32_rr_arb2
    import hs32_sram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic       grant
);
    always_comb grant = &req ? (prio_mode ? GNT_CPU : ~last) : (req[1] ? GNT_WB : GNT_CPU);
endmodule

// File: rtl/hs32_sram_arb.sv
// hs32_sram_arb: CPU/Wishbone sharing of one SRAM port via a fixed 4-cycle FSM (HS32_SRAM_ARB_CPU_PRIO_EN selects fixed CPU priority)
module hs32_sram_arb
    import hs32_sram_pkg::*;
#(
    parameter int          AW = DEFAULT_AW,
    parameter logic [31:0] WB_BASE = 32'h3000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cpu_stb,
    input  logic          cpu_we,
    input  logic [3:0]    cpu_sel,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_dtw,
    output logic          cpu_ack,
    output logic [31:0]   cpu_dtr,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          ram_csb,
    output logic          ram_web,
    output logic [3:0]    ram_wmask,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);
`ifdef HS32_SRAM_ARB_CPU_PRIO_EN
    localparam logic PRIO_MODE = 1'b1;
`else
    localparam logic PRIO_MODE = 1'b0;
`endif
    state_t state;
    logic gnt, last_grant, pick, req_cpu, req_wb, sel_we;
    logic [3:0] sel_mask;
    logic [AW-1:0] sel_addr;
    logic [31:0] sel_data;
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];
    always_comb begin
        req_cpu = cpu_stb;
        req_wb = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2]);
        sel_we = pick ? wbs_we_i : cpu_we;
        sel_mask = sel_we ? (pick ? wbs_sel_i : cpu_sel) : 4'h0;
        sel_addr = pick ? wbs_adr_i[AW+1:2] : cpu_addr;
        sel_data = pick ? wbs_dat_i : cpu_dtw;
    end
    hs32_rr_arb2 u_arb (
        .req      ({req_wb, req_cpu}),
        .last     (last_grant),
        .prio_mode(PRIO_MODE),
        .grant    (pick)
    );
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            gnt <= GNT_CPU;
            last_grant <= GNT_WB;
            ram_csb <= 1'b1;
            ram_web <= 1'b1;
            ram_wmask <= 4'h0;
            ram_addr <= '0;
            ram_din <= 32'h0;
            cpu_ack <= 1'b0;
            wbs_ack_o <= 1'b0;
            cpu_dtr <= 32'h0;
            wbs_dat_o <= 32'h0;
        end else begin
            cpu_ack <= 1'b0;
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: if (req_cpu | req_wb) begin
                    gnt <= pick;
                    last_grant <= pick;
                    ram_csb <= 1'b0;
                    ram_web <= ~sel_we;
                    ram_wmask <= sel_mask;
                    ram_addr <= sel_addr;
                    ram_din <= sel_data;
                    state <= ISSUE;
                end
                ISSUE: begin
                    ram_csb <= 1'b1;
                    ram_web <= 1'b1;
                    state <= CAPT;
                end
                // ram_dout is valid here, one cycle after the SRAM sampled csb low
                CAPT: begin
                    if (gnt == GNT_WB) begin
                        wbs_dat_o <= ram_dout;
                        wbs_ack_o <= 1'b1;
                    end else begin
                        cpu_dtr <= ram_dout;
                        cpu_ack <= 1'b1;
                    end
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs32_sram_arb.sv
// tb_hs32_sram_arb: directed self-checking bench for hs32_sram_arb with a behavioural SRAM
module tb_hs32_sram_arb;
    logic clk = 1'b0, rst = 1'b1;
    logic cpu_stb = 1'b0, cpu_we = 1'b0;
    logic [3:0] cpu_sel = 4'h0;
    logic [7:0] cpu_addr = 8'h0;
    logic [31:0] cpu_dtw = 32'h0;
    logic cpu_ack;
    logic [31:0] cpu_dtr;
    logic wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0] wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic ram_csb, ram_web;
    logic [3:0] ram_wmask;
    logic [7:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;
    logic [31:0] mem [256] = '{default: 32'h0};
    int checks = 0, errors = 0;
    int csb_lo = 0, cpu_acks = 0, wb_acks = 0;
    logic [3:0] last_wmask = 4'h0;

    hs32_sram_arb dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cpu_stb  (cpu_stb),
        .cpu_we   (cpu_we),
        .cpu_sel  (cpu_sel),
        .cpu_addr (cpu_addr),
        .cpu_dtw  (cpu_dtw),
        .cpu_ack  (cpu_ack),
        .cpu_dtr  (cpu_dtr),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .ram_csb  (ram_csb),
        .ram_web  (ram_web),
        .ram_wmask(ram_wmask),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_ack) cpu_acks++;
        if (wbs_ack_o) wb_acks++;
        if (!ram_csb) begin
            csb_lo++;
            last_wmask = ram_wmask;
            ram_dout <= mem[ram_addr];
            if (!ram_web)
                for (int b = 0; b < 4; b++)
                    if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_acc(input logic we, input logic [3:0] sel, input logic [7:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output int n);
        cpu_stb = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = a; cpu_dtw = d; n = 0;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            cyc();
            if (cpu_ack) n = i;
        end
        rd = cpu_dtr;
        cpu_stb = 1'b0; cpu_we = 1'b0;
        cyc();
        chk("cpu_ack_pulse", {31'h0, cpu_ack}, 32'h0);
    endtask

    task automatic wb_acc(input logic we, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int n);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = a; wbs_dat_i = d; n = 0;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            cyc();
            if (wbs_ack_o) n = i;
        end
        rd = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        cyc();
        chk("wb_ack_pulse", {31'h0, wbs_ack_o}, 32'h0);
    endtask

    task automatic race(input logic hold_cpu, output int tc, output int tw, output int nc);
        tc = 0; tw = 0; nc = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (cpu_ack) begin
                nc++;
                if (tc == 0) tc = i;
                if (!hold_cpu) cpu_stb = 1'b0;
            end
            if (wbs_ack_o) begin
                if (tw == 0) tw = i;
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
        end
        cpu_stb = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (5) cyc();
    endtask

    initial begin
        logic [31:0] rd;
        int n, tc, tw, nc, c0, w0;
        cyc();
        chk("rst_csb", {31'h0, ram_csb}, 32'h1);
        chk("rst_web", {31'h0, ram_web}, 32'h1);
        chk("rst_wmask", {28'h0, ram_wmask}, 32'h0);
        chk("rst_addr", {24'h0, ram_addr}, 32'h0);
        chk("rst_din", ram_din, 32'h0);
        chk("rst_acks", {30'h0, cpu_ack, wbs_ack_o}, 32'h0);
        chk("rst_cpu_dtr", cpu_dtr, 32'h0);
        chk("rst_wbs_dat", wbs_dat_o, 32'h0);
        rst = 1'b0;
        cyc();

        c0 = csb_lo;
        cpu_acc(1'b1, 4'hF, 8'h12, 32'hDEAD_BEEF, rd, n);
        chk("cpu_wr_lat", n, 3);
        chk("cpu_wr_csb_cycles", csb_lo - c0, 1);
        chk("cpu_wr_wmask", {28'h0, last_wmask}, 32'hF);
        cpu_acc(1'b0, 4'hF, 8'h12, 32'h0, rd, n);
        chk("cpu_rd_data", rd, 32'hDEAD_BEEF);
        chk("cpu_rd_lat", n, 3);
        chk("wb_dat_idle_hold", wbs_dat_o, 32'h0);

        wb_acc(1'b1, 4'b0011, 32'h3000_0048, 32'h1234_5678, rd, n);
        chk("wb_wr_lat", n, 3);
        chk("wb_wr_wmask", {28'h0, last_wmask}, 32'h3);
        chk("cpu_dtr_hold", cpu_dtr, 32'hDEAD_BEEF);
        wb_acc(1'b0, 4'hF, 32'h3000_0048, 32'h0, rd, n);
        chk("wb_rd_merge", rd, 32'hDEAD_5678);

        cpu_acc(1'b1, 4'h0, 8'h12, 32'h0, rd, n);
        chk("sel0_acked", n, 3);
        chk("sel0_wmask", {28'h0, last_wmask}, 32'h0);
        cpu_acc(1'b0, 4'hF, 8'h12, 32'h0, rd, n);
        chk("sel0_unchanged", rd, 32'hDEAD_5678);

        cpu_acc(1'b1, 4'hF, 8'hFF, 32'hA5A5_A5A5, rd, n);
        wb_acc(1'b0, 4'hF, 32'h3000_03FC, 32'h0, rd, n);
        chk("top_word_wb_rd", rd, 32'hA5A5_A5A5);

        c0 = csb_lo; w0 = wb_acks;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h2000_0000;
        repeat (10) cyc();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("oow_no_ack", wb_acks - w0, 0);
        chk("oow_no_csb", csb_lo - c0, 0);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_03FC;
        race(1'b0, tc, tw, nc);
        chk("cont_cpu_first", tc, 3);
        chk("cont_wb_second", tw, 7);
        chk("cont_cpu_data", cpu_dtr, 32'hDEAD_5678);
        chk("cont_wb_data", wbs_dat_o, 32'hA5A5_A5A5);

        cpu_stb = 1'b1; cpu_addr = 8'hFF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0048;
        race(1'b1, tc, tw, nc);
`ifdef HS32_SRAM_ARB_CPU_PRIO_EN
        chk("hold_wb_starved", tw, 0);
        chk("hold_cpu_acks", nc, 3);
`else
        chk("hold_wb_served", tw, 7);
        chk("hold_cpu_acks", nc, 2);
`endif

        c0 = cpu_acks;
        cpu_stb = 1'b1; cpu_we = 1'b1; cpu_sel = 4'hF; cpu_addr = 8'h20; cpu_dtw = 32'h1111_1111;
        cyc();
        chk("abort_issue_csb", {31'h0, ram_csb}, 32'h0);
        rst = 1'b1;
        #1;
        chk("abort_csb", {31'h0, ram_csb}, 32'h1);
        chk("abort_web", {31'h0, ram_web}, 32'h1);
        chk("abort_acks", {30'h0, cpu_ack, wbs_ack_o}, 32'h0);
        cpu_stb = 1'b0; cpu_we = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        chk("abort_no_ack", cpu_acks - c0, 0);
        cpu_acc(1'b0, 4'hF, 8'h20, 32'h0, rd, n);
        chk("abort_next_lat", n, 3);
        chk("abort_no_write", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hs32_sram_arb.md
Name: hs32_sram_arb

Overview:
Two-port arbiter sharing one 256x32 sky130 1rw1r SRAM macro (port 0 only) between the HS32 CPU memory port and the management Wishbone slave.
- Sequences every access through a fixed 4-cycle FSM, driving registered SRAM controls (csb/web/wmask/addr/din) and returning registered read data with a one-cycle ack.
- Sits between hs32_core1 and the SRAM instances in the user project wrapper, so firmware can preload or inspect RAM while the core runs.

Parameters:
AW, 8, SRAM word-address width (256 words)
WB_BASE, 32'h3000_0000, Wishbone window base; match on wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2]

Ports:
wb_clk_i  in  1  system clock; all state on rising edge
wb_rst_i  in  1  reset, asynchronous, active-high
cpu_stb  in  1  CPU request; held until cpu_ack
cpu_we  in  1  CPU write enable
cpu_sel  in  4  CPU byte enables
cpu_addr  in  AW  CPU word address
cpu_dtw  in  32  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_dtr  out  32  CPU read data, valid with cpu_ack
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic controls
wbs_sel_i  in  4  Wishbone byte selects
wbs_adr_i  in  32  Wishbone byte address; word = wbs_adr_i[AW+1:2]
wbs_dat_i  in  32  Wishbone write data
wbs_ack_o  out  1  one-cycle Wishbone ack
wbs_dat_o  out  32  Wishbone read data, valid with ack
ram_csb  out  1  SRAM chip select, active-low
ram_web  out  1  SRAM write enable, active-low
ram_wmask  out  4  SRAM byte write mask
ram_addr  out  AW  SRAM address
ram_din  out  32  SRAM write data
ram_dout  in  32  SRAM read data, valid the cycle after csb sampled low

Behaviour:
- Reset: state=IDLE; ram_csb=1, ram_web=1, ram_wmask=0, ram_addr=0, ram_din=0; cpu_ack=0, wbs_ack_o=0, cpu_dtr=0, wbs_dat_o=0; last_grant=WB.
- Requests:
  - req_cpu = cpu_stb.
  - req_wb = wbs_cyc_i & wbs_stb_i & window match.
  - An out-of-window WB request is ignored and never acked.
- FSM IDLE -> ISSUE -> CAPT -> ACK -> IDLE, one state per cycle.
- IDLE:
  - If any request is present, pick a winner, register its we/sel/addr/data into the ram_* outputs (ram_csb<=0, ram_web<=~we, ram_wmask<=we?sel:0), set grant and last_grant, and go to ISSUE.
  - Otherwise stay in IDLE with ram_csb=1.
- ISSUE: ram_csb=0 for this cycle only; the SRAM captures the command at the ending edge. At that edge ram_csb<=1 and ram_web<=1.
- CAPT: ram_dout is valid. At the ending edge:
  - The granted port's dtr/dat_o <= ram_dout.
  - The granted port's ack <= 1.
  - Writes also load ram_dout, value don't-care.
- ACK: ack is high for exactly this cycle. The requester's stb is still high, so it is not re-sampled. Next state is IDLE, where ack returns to 0.
- Latency: 3 cycles from the request-sampling edge to ack high. Throughput: one access per 4 cycles.
- Arbitration:
  - Two-way round-robin on last_grant: on contention, grant the port not served last. A lone request is granted immediately.
  - First contention after reset goes to the CPU.
- Data out registers hold their value between acks. The non-granted port's ack stays 0.
- Boundary conditions:
  - stb dropped mid-access: the SRAM access still completes and the ack still pulses; the requester ignores it.
  - Write with sel=0: ram_wmask=0, no bytes change, still acked.
  - Address wraps within AW bits; upper CPU bits do not exist.
  - Reset mid-access: immediate return to IDLE with ram_csb=1; no ack is issued for the aborted access.

Optional Feature:
HS32_SRAM_ARB_CPU_PRIO_EN:
- Defined: fixed priority. The CPU always wins contention and last_grant is unused. WB may starve while cpu_stb is held continuously.
- Undefined: round-robin as specified above.

Decomposition:
- Package hs32_sram_pkg:
  - FSM state encoding (IDLE/ISSUE/CAPT/ACK, 2 bits).
  - Grant encoding GNT_CPU=0, GNT_WB=1.
  - SRAM_RD_LAT=1 constant.
  - Default AW.
- One sub-module, hs32_rr_arb2: combinational 2-request picker with inputs req[1:0], last, prio_mode and output grant. It holds both the round-robin and the fixed-priority logic.

Test Plan:
- CPU write 0xDEADBEEF, sel=4'hF, addr 0x12 -> ram_csb low exactly 1 cycle with wmask=F; cpu_ack 3 cycles after sampling. Then CPU read 0x12 -> cpu_dtr=0xDEADBEEF.
- WB write 0x3000_0048 with sel=4'b0011, data 0x1234_5678 over 0xDEADBEEF at word 0x12 -> later read returns 0xDEAD5678.
- CPU and WB both assert in the same cycle after reset -> CPU served first and WB second; acks 4 cycles apart.
- CPU continuously requesting plus one WB request -> WB acked within 8 cycles (round-robin). With HS32_SRAM_ARB_CPU_PRIO_EN -> no WB ack while the CPU is held.
- WB access to 0x2000_0000 -> wbs_ack_o never asserts and ram_csb stays 1.
- wb_rst_i pulsed during ISSUE -> ram_csb=1 and acks 0 immediately; no ack follows; the next request completes normally.
